csa_tap_sched: RTL and testbench

Time-multiplexes one carry-save serial multiply block across TAPS filter taps of the adaptive filter datapath. For each tap it:
- selects the tap weight;
- clears the block's feedback path;
- streams the sample operand bit-serially for BITS cycles;
- captures the resulting sum and carry vectors;
- hands them downstream over a valid/ready interface.

The block sits between the filter top-level control (start/done) and the CSA datapath instance.

---
 rtl/csa_sched_pkg.sv | 14 +
 rtl/csa_bit_cnt.sv | 28 ++
 rtl/csa_tap_sched.sv | 109 ++++++++++
 tb/tb_csa_tap_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_sched_pkg.sv
// csa_sched_pkg: shared FSM encoding and default sizing for the CSA tap scheduler.
package csa_sched_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_HOLD, S_DONE} state_t;

    localparam int DEF_TAPS = 4;
    localparam int DEF_WW   = 10;
    localparam int DEF_BITS = 10;

    function automatic int tw_of(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/csa_bit_cnt.sv
// csa_bit_cnt: loadable up/down counter with a terminal-count flag.
module csa_bit_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         ld,
    input  logic         en,
    input  logic         dn,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = ld ? ld_val : (en ? (dn ? cnt_q - W'(1) : cnt_q + W'(1)) : cnt_q);

    always_ff @(posedge clk or negedge r) begin
        if (!r) cnt_q <= '0;
        else    cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/csa_tap_sched.sv
// csa_tap_sched: time-multiplexes one carry-save serial multiplier across TAPS taps,
// streaming each sample bit-serially and handing sum/carry downstream via valid/ready.
module csa_tap_sched
    import csa_sched_pkg::*;
#(
    parameter int TAPS = DEF_TAPS,
    parameter int WW   = DEF_WW,
    parameter int BITS = DEF_BITS,
    parameter int TW   = tw_of(TAPS)
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TAPS*WW-1:0]   w_flat,
    input  logic [TAPS*BITS-1:0] x_flat,
    input  logic [WW-1:0]        csa_s,
    input  logic [WW-1:0]        csa_c,
    output logic [WW-1:0]        csa_w,
    output logic                 csa_t,
    output logic                 csa_clr,
    output logic                 x_bit,
    output logic                 busy,
    output logic                 done,
    output logic [WW-1:0]        res_s,
    output logic [WW-1:0]        res_c,
    output logic [TW-1:0]        res_tap,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam int BW = $clog2(BITS);
    localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

    state_t          state_q, state_d;
    logic [WW-1:0]   w_sh_q [TAPS];
    logic [BITS-1:0] x_sh_q [TAPS];
    logic [WW-1:0]   res_s_q, res_c_q;
    logic [TW-1:0]   res_tap_q;
    logic [TW-1:0]   tap;
    logic [BW-1:0]   bit_idx;
    logic            tap_tc, bit_tc, take, accept;

    assign take   = (state_q == S_IDLE) && start;
    assign accept = (state_q == S_HOLD) && res_ready && !abort;

    // Tap advance compares against TAPS-1, so non-power-of-two TAPS never visits a phantom tap.
    csa_bit_cnt #(.W(TW)) u_tap_cnt (
        .clk(clk), .r(r), .ld(take), .en(accept && !tap_tc), .dn(1'b0),
        .ld_val('0), .tc_val(TAP_LAST), .cnt(tap), .tc(tap_tc)
    );

    csa_bit_cnt #(.W(BW)) u_bit_cnt (
        .clk(clk), .r(r), .ld(state_q == S_LOAD), .en((state_q == S_RUN) && !bit_tc), .dn(1'b0),
        .ld_val('0), .tc_val(BIT_LAST), .cnt(bit_idx), .tc(bit_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   state_d = bit_tc ? S_CAPT : S_RUN;
            S_CAPT:  state_d = S_HOLD;
            S_HOLD:  state_d = res_ready ? (tap_tc ? S_DONE : S_LOAD) : S_HOLD;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
        busy      = state_q inside {S_LOAD, S_RUN, S_CAPT, S_HOLD};
        csa_clr   = state_q == S_LOAD;
        csa_t     = state_q == S_RUN;
        done      = state_q == S_DONE;
        res_valid = state_q == S_HOLD;
        csa_w     = (state_q inside {S_LOAD, S_RUN, S_CAPT}) ? w_sh_q[tap] : '0;
        x_bit     = (state_q == S_RUN) ? x_sh_q[tap][bit_idx] : 1'b0;
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q   <= S_IDLE;
            res_s_q   <= '0;
            res_c_q   <= '0;
            res_tap_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                w_sh_q[k] <= '0;
                x_sh_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (take) begin
                for (int k = 0; k < TAPS; k++) begin
                    w_sh_q[k] <= w_flat[k*WW +: WW];
                    x_sh_q[k] <= x_flat[k*BITS +: BITS];
                end
            end
            if (state_q == S_CAPT) begin
                res_s_q   <= csa_s;
                res_c_q   <= csa_c;
                res_tap_q <= tap;
            end
        end
    end

    assign res_s   = res_s_q;
    assign res_c   = res_c_q;
    assign res_tap = res_tap_q;

endmodule

// File: tb/tb_csa_tap_sched.sv
// tb_csa_tap_sched: directed and randomized passes checked against a cycle timeline
// built from the scheduling rules (LOAD, BITS run cycles, capture, hold until ready).
module tb_csa_tap_sched;

    localparam int TAPS = 4;
    localparam int WW   = 10;
    localparam int BITS = 10;
    localparam int TW   = 2;
    localparam int T3   = 3;

    logic                 clk = 1'b0, r = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [TAPS*WW-1:0]   w_flat = '0;
    logic [TAPS*BITS-1:0] x_flat = '0;
    logic [WW-1:0]        csa_s = '0, csa_c = '0;
    logic [WW-1:0]        csa_w, res_s, res_c;
    logic                 csa_t, csa_clr, x_bit, busy, done, res_valid;
    logic [TW-1:0]        res_tap;

    logic                 start3 = 1'b0;
    logic [T3*WW-1:0]     w3 = '0;
    logic [T3*BITS-1:0]   x3 = '0;
    logic [WW-1:0]        csa_w3, res_s3, res_c3;
    logic                 csa_t3, csa_clr3, x_bit3, busy3, done3, res_valid3;
    logic [1:0]           res_tap3;

    csa_tap_sched #(.TAPS(TAPS), .WW(WW), .BITS(BITS), .TW(TW)) dut (
        .clk(clk), .r(r), .start(start), .abort(abort), .w_flat(w_flat), .x_flat(x_flat),
        .csa_s(csa_s), .csa_c(csa_c), .csa_w(csa_w), .csa_t(csa_t), .csa_clr(csa_clr),
        .x_bit(x_bit), .busy(busy), .done(done), .res_s(res_s), .res_c(res_c),
        .res_tap(res_tap), .res_valid(res_valid), .res_ready(res_ready)
    );

    csa_tap_sched #(.TAPS(T3), .WW(WW), .BITS(BITS), .TW(2)) dut3 (
        .clk(clk), .r(r), .start(start3), .abort(1'b0), .w_flat(w3), .x_flat(x3),
        .csa_s(csa_s), .csa_c(csa_c), .csa_w(csa_w3), .csa_t(csa_t3), .csa_clr(csa_clr3),
        .x_bit(x_bit3), .busy(busy3), .done(done3), .res_s(res_s3), .res_c(res_c3),
        .res_tap(res_tap3), .res_valid(res_valid3), .res_ready(1'b1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    logic [WW-1:0]   w_m [TAPS];
    logic [BITS-1:0] x_m [TAPS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int k = 0; k < TAPS; k++) begin
            w_flat[k*WW +: WW]     = WW'($urandom);
            x_flat[k*BITS +: BITS] = BITS'($urandom);
        end
    endtask

    task automatic load_pass(input bit directed);
        for (int k = 0; k < TAPS; k++) begin
            w_m[k] = directed ? WW'(k + 1) : WW'($urandom);
            x_m[k] = directed ? '1 : BITS'($urandom);
            w_flat[k*WW +: WW]     = w_m[k];
            x_flat[k*BITS +: BITS] = x_m[k];
        end
        start = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(res_valid), 0);
        chk({tag, "_t"}, 32'(csa_t), 0);
        chk({tag, "_clr"}, 32'(csa_clr), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic check_zero(input string tag);
        check_idle(tag);
        chk({tag, "_w"}, 32'(csa_w), 0);
        chk({tag, "_xbit"}, 32'(x_bit), 0);
        chk({tag, "_res_s"}, 32'(res_s), 0);
        chk({tag, "_res_c"}, 32'(res_c), 0);
        chk({tag, "_res_tap"}, 32'(res_tap), 0);
    endtask

    // Entry: the cycle in LOAD. Exit: the CAPT cycle, with csa_s/csa_c driven to es/ec.
    task automatic to_hold(input int k, input bit restart, output logic [WW-1:0] es, output logic [WW-1:0] ec);
        chk("load_clr", 32'(csa_clr), 1);
        chk("load_t", 32'(csa_t), 0);
        chk("load_w", 32'(csa_w), 32'(w_m[k]));
        chk("load_busy", 32'(busy), 1);
        chk("load_xbit", 32'(x_bit), 0);
        chk("load_valid", 32'(res_valid), 0);
        for (int b = 0; b < BITS; b++) begin
            res_ready = 1'($urandom);
            start = restart && b == 3;
            if (restart && b == 3) scramble();
            step();
            chk("run_t", 32'(csa_t), 1);
            chk("run_clr", 32'(csa_clr), 0);
            chk("run_x", 32'(x_bit), 32'(x_m[k][b]));
            chk("run_w", 32'(csa_w), 32'(w_m[k]));
        end
        start = 1'b0;
        res_ready = 1'($urandom);
        step();
        chk("capt_t", 32'(csa_t), 0);
        chk("capt_valid", 32'(res_valid), 0);
        chk("capt_busy", 32'(busy), 1);
        es = WW'($urandom);
        ec = WW'($urandom);
        csa_s = es;
        csa_c = ec;
    endtask

    task automatic hold(input int k, input int stall, input logic [WW-1:0] es, input logic [WW-1:0] ec);
        step();
        for (int s = 0; s <= stall; s++) begin
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_s", 32'(res_s), 32'(es));
            chk("hold_c", 32'(res_c), 32'(ec));
            chk("hold_tap", 32'(res_tap), 32'(k));
            chk("hold_busy", 32'(busy), 1);
            csa_s = WW'($urandom);
            csa_c = WW'($urandom);
            res_ready = (s == stall);
            step();
        end
        res_ready = 1'b0;
    endtask

    task automatic full_pass(input bit directed, input int stall_tap, input int stall_n, input int restart_tap);
        logic [WW-1:0] es, ec;
        load_pass(directed);
        step();
        start = 1'b0;
        scramble();
        for (int k = 0; k < TAPS; k++) begin
            to_hold(k, k == restart_tap, es, ec);
            hold(k, (k == stall_tap) ? stall_n : 0, es, ec);
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_valid", 32'(res_valid), 0);
        step();
        check_idle("after_done");
        step();
        chk("single_done", 32'(done), 0);
    endtask

    initial begin
        logic [WW-1:0] es, ec;
        int vt[$], vk[$], dt[$];
        #1 r = 1'b0;
        #1 check_zero("reset");
        step();
        step();
        r = 1'b1;
        step();
        check_idle("post_reset");

        full_pass(1'b1, -1, 0, -1);
        full_pass(1'b0, 1, 7, -1);
        full_pass(1'b0, -1, 0, 2);

        load_pass(1'b0);
        step();
        start = 1'b0;
        scramble();
        to_hold(0, 1'b0, es, ec);
        hold(0, 0, es, ec);
        chk("abort_load_w", 32'(csa_w), 32'(w_m[1]));
        for (int b = 0; b <= 5; b++) begin
            step();
            chk("abort_run_x", 32'(x_bit), 32'(x_m[1][b]));
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_nodone", 32'(done), 0);
            chk("abort_busy", 32'(busy), 0);
        end
        full_pass(1'b0, 0, 2, -1);

        load_pass(1'b0);
        step();
        start = 1'b0;
        to_hold(0, 1'b0, es, ec);
        hold(0, 0, es, ec);
        to_hold(1, 1'b0, es, ec);
        step();
        chk("rst_hold_valid", 32'(res_valid), 1);
        #2 r = 1'b0;
        #1 check_zero("rst_async");
        step();
        step();
        r = 1'b1;
        check_zero("rst_release");
        full_pass(1'b0, 3, 1, -1);

        repeat (4) full_pass(1'b0, int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 5)), -1);

        for (int k = 0; k < T3; k++) begin
            w3[k*WW +: WW]     = WW'($urandom);
            x3[k*BITS +: BITS] = BITS'($urandom);
        end
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (res_valid3) begin
                vt.push_back(t);
                vk.push_back(int'(res_tap3));
            end
            if (done3) dt.push_back(t);
            step();
        end
        chk("t3_nvalid", 32'(vt.size()), T3);
        for (int k = 0; k < T3; k++) begin
            chk("t3_tap", (k < vk.size()) ? 32'(vk[k]) : '1, 32'(k));
            chk("t3_valid_t", (k < vt.size()) ? 32'(vt[k]) : '1, 32'(k * (BITS + 3) + BITS + 2));
        end
        chk("t3_ndone", 32'(dt.size()), 1);
        chk("t3_done_t", (dt.size() > 0) ? 32'(dt[0]) : '1, 32'(T3 * (BITS + 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
